// File: rtl/bike_light_pkg.sv
// Bike light controller shared types and default constants.
// Mode encodings include DIM, used only when BIKE_LIGHT_DIM_EN is defined.
package bike_light_pkg;

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    ON    = 2'd1,
    BLINK = 2'd2,
    DIM   = 2'd3
  } mode_e;

  localparam int RATE_INIT_DEF = 3;
  localparam int RATE_MAX_DEF  = 6;

endpackage

// File: rtl/bike_light_if.sv
// Control/status bundle between the bike light controller and its user.
// master drives the button pulses and blink waveform; slave is the controller.
interface bike_light_if;

  logic       next;
  logic       faster;
  logic       slower;
  logic       blink_in;
  logic       shift_left;
  logic       shift_right;
  logic       count_en;
  logic       fast;
  logic       light_out;
  logic [1:0] mode;
  logic [2:0] rate;

  modport master (
    output next, faster, slower, blink_in,
    input  shift_left, shift_right, count_en,
    input  fast, light_out, mode, rate
  );

  modport slave (
    input  next, faster, slower, blink_in,
    output shift_left, shift_right, count_en,
    output fast, light_out, mode, rate
  );

endinterface

// File: rtl/bike_light_controller_tick_prescaler.sv
// Blink timebase: counts 0..TICK_DIV-1 while enabled, held at 0 otherwise.
// tick is registered so it lands on the cycle the count shows its wrap.
module tick_prescaler #(
  parameter int TICK_DIV = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] cnt;
  logic         tick_q;

  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      cnt    <= '0;
      tick_q <= 1'b0;
    end else if (cnt == LAST) begin
      cnt    <= '0;
      tick_q <= 1'b1;
    end else begin
      cnt    <= cnt + W'(1);
      tick_q <= 1'b0;
    end
  end

  // A wrap just before leaving BLINK must not leak out.
  assign tick = tick_q & enable;

endmodule

// File: rtl/bike_light_controller.sv
// Bike light mode FSM and blink-rate tracker driving an external blinker.
// Optional DIM mode (25% duty) is built when BIKE_LIGHT_DIM_EN is defined.
module bike_light_controller
  import bike_light_pkg::*;
#(
  parameter int TICK_DIV  = 50000,
  parameter int RATE_INIT = RATE_INIT_DEF,
  parameter int RATE_MAX  = RATE_MAX_DEF
) (
  input  logic         clk,
  input  logic         reset,
  bike_light_if.slave  bus
);

  localparam logic [2:0] R_INIT = 3'(RATE_INIT);
  localparam logic [2:0] R_MAX  = 3'(RATE_MAX);

  mode_e      mode_q, mode_d;
  logic [2:0] rate_q, rate_d;
  logic       sl_q, sl_d;
  logic       sr_q, sr_d;
  logic       in_blink;
  logic       req_up, req_dn;
  logic       lamp;

  assign in_blink = (mode_q == BLINK);

  assign req_up = in_blink && !bus.next
               && bus.slower && !bus.faster
               && (rate_q < R_MAX);

  assign req_dn = in_blink && !bus.next
               && bus.faster && !bus.slower
               && (rate_q != 3'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q <= OFF;
      rate_q <= R_INIT;
      sl_q   <= 1'b0;
      sr_q   <= 1'b0;
    end else begin
      mode_q <= mode_d;
      rate_q <= rate_d;
      sl_q   <= sl_d;
      sr_q   <= sr_d;
    end
  end

  always_comb begin
    mode_d = mode_q;
    rate_d = rate_q;
    sl_d   = 1'b0;
    sr_d   = 1'b0;
    if (bus.next) begin
      unique case (mode_q)
        OFF:   mode_d = ON;
`ifdef BIKE_LIGHT_DIM_EN
        ON:    mode_d = DIM;
        DIM:   mode_d = BLINK;
`else
        ON:    mode_d = BLINK;
        DIM:   mode_d = OFF;
`endif
        BLINK: mode_d = OFF;
        default: mode_d = OFF;
      endcase
    end
    unique case (1'b1)
      req_up: begin
        rate_d = rate_q + 3'd1;
        sl_d   = 1'b1;
      end
      req_dn: begin
        rate_d = rate_q - 3'd1;
        sr_d   = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef BIKE_LIGHT_DIM_EN
  logic [1:0] phase_q;

  // Phase restarts at 0 on every DIM entry.
  always_ff @(posedge clk) begin
    if (reset || mode_q != DIM) begin
      phase_q <= 2'd0;
    end else begin
      phase_q <= phase_q + 2'd1;
    end
  end
`endif

  always_comb begin
    lamp = 1'b0;
    unique case (mode_q)
      OFF:   lamp = 1'b0;
      ON:    lamp = 1'b1;
      BLINK: lamp = bus.blink_in;
`ifdef BIKE_LIGHT_DIM_EN
      DIM:   lamp = (phase_q == 2'd0);
`else
      DIM:   lamp = 1'b0;
`endif
      default: lamp = 1'b0;
    endcase
  end

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_presc (
    .clk    (clk),
    .reset  (reset),
    .enable (in_blink),
    .tick   (bus.count_en)
  );

  assign bus.mode        = mode_q;
  assign bus.rate        = rate_q;
  assign bus.fast        = (rate_q == 3'd0);
  assign bus.shift_left  = sl_q;
  assign bus.shift_right = sr_q;
  assign bus.light_out   = lamp;

endmodule
